kernel_bc_fifo_rr_merge: RTL and testbench
==========================================

Name: kernel_bc_fifo_rr_merge

Overview:
- Round-robin merger that shares one downstream HLS-style FIFO write port among NUM_PORTS upstream FIFO read ports.
- Uses empty_n/read on the input side and full_n/write on the output side.
- Pops at most one word per cycle from the selected input into a registered output stage, tagged with the source index.
- Sits between per-PE result FIFOs and the shared kernel_bc write-back FIFO.

Parameters:
- NUM_PORTS, 4, number of upstream FIFOs; power of two, 2..16.
- ID_WIDTH, 2, width of the source index; equals log2(NUM_PORTS).
- DATA_WIDTH, 64, word width.
- BURST_MAX, 4, maximum consecutive words taken from one port before rotation; range 1..255.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- en  input  1  arbitration enable; 0 blocks new pops, output stage still drains.
- in_empty_n  input  NUM_PORTS  per-port not-empty from the upstream FIFOs.
- in_dout  input  NUM_PORTS*DATA_WIDTH  per-port head data; port i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_read  output  NUM_PORTS  one-hot pop strobe to the upstream FIFOs.
- out_full_n  input  1  downstream not-full.
- out_write  output  1  downstream write strobe.
- out_din  output  DATA_WIDTH  downstream write data.
- out_src  output  ID_WIDTH  source port of out_din.

Behaviour:
- Registered state: out_valid, out_din, out_src, gnt (ID_WIDTH), cnt (8 bits).
- Reset values: out_valid=0, out_din=0, out_src=0, gnt=0, cnt=0. Resulting outputs: out_write=0, in_read=0.
- out_write = out_valid.
- stall = out_valid & ~out_full_n.
- Selection runs only when en=1 and stall=0:
  - Continue: if in_empty_n[gnt]=1 and cnt<BURST_MAX, sel=gnt.
  - Rotate: otherwise scan gnt+1, gnt+2, ..., gnt+NUM_PORTS (mod NUM_PORTS; gnt itself is checked last) and take the first port with in_empty_n=1.
  - pop=1 when a sel exists, else pop=0.
- in_read: combinational one-hot at sel when pop=1; all zeros otherwise. At most one bit is ever set.
- On pop, at the clock edge:
  - out_din <= in_dout[sel]; out_src <= sel; out_valid <= 1; gnt <= sel.
  - cnt <= cnt+1 on the continue path; cnt <= 1 on the rotate path, including rotate back to gnt itself.
- No pop and stall=0: out_valid <= 0 (the word was accepted or none was held). If en=1 with no requester, cnt <= 0 and gnt holds.
- stall=1: all state holds; out_din and out_src stay stable; in_read=0.
- en=0 and stall=0: no pop; out_valid <= 0; gnt and cnt hold.
- Latency: in_read at cycle t gives out_write at t+1. Sustained throughput is 1 word per cycle, with no bubble at burst boundaries or on rotation.
- Fairness: a continuously non-empty port waits at most (NUM_PORTS-1)*BURST_MAX pops.
- Per-port word order is preserved.
- Reset mid-transfer discards the held word.
- in_dout is sampled only for the sel port; other ports' data is ignored.

Test Plan:
1. Reset with all inputs idle -> out_write=0, in_read=0, out_src=0, out_din=0 on the first cycle after reset.
2. Only port 2 non-empty, 3 words A,B,C; out_full_n=1; en=1 -> in_read=4'b0100 for 3 cycles; out_write=1 for the next 3 cycles with A,B,C and out_src=2.
3. All 4 ports always non-empty; BURST_MAX=4; out_full_n=1 -> out_src sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; exactly one in_read bit per cycle.
4. Port 1 holds 10 words, others empty -> 10 consecutive pops from port 1 with no idle cycle; cnt wraps 4 to 1 twice.
5. out_full_n=0 for 5 cycles while out_valid=1 -> out_write=1 and out_din/out_src stable; in_read=0; after release, one word accepted per cycle.
6. en=0 mid-burst -> no further in_read; out_write drops after the held word is accepted. Assert reset with out_valid=1 -> out_write=0 next cycle; gnt=0, cnt=0.

Source files
------------

// File: rtl/kernel_bc_fifo_rr_merge.sv
// ---------------------------------------------------------------------------
// kernel_bc_fifo_rr_merge
//
// Round-robin merger. It shares one downstream HLS-style FIFO write port among
// NUM_PORTS upstream FIFO read ports. It pops at most one word per cycle from
// the selected upstream FIFO into a registered output stage. Each word is
// tagged with the index of the port it came from. A port may keep the grant
// for up to BURST_MAX consecutive words before the grant rotates.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   en          arbitration enable (0 blocks new pops; output stage drains)
//   in_empty_n  per-port not-empty flags from the upstream FIFOs
//   in_dout     per-port head data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_read     one-hot pop strobe to the upstream FIFOs
//   out_full_n  downstream not-full
//   out_write   downstream write strobe (output stage holds a word)
//   out_din     downstream write data
//   out_src     source port index of out_din
// ---------------------------------------------------------------------------
module kernel_bc_fifo_rr_merge #(
  parameter int NUM_PORTS  = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_MAX  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic [NUM_PORTS-1:0]            in_empty_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_dout,
  output logic [NUM_PORTS-1:0]            in_read,
  input  logic                            out_full_n,
  output logic                            out_write,
  output logic [DATA_WIDTH-1:0]           out_din,
  output logic [ID_WIDTH-1:0]             out_src
);

  // Registered state
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_din_reg;
  logic [ID_WIDTH-1:0]   out_src_reg;
  logic [ID_WIDTH-1:0]   gnt_reg;
  logic [7:0]            cnt_reg;

  // Selection logic
  logic                  stall;
  logic                  can_continue;
  logic                  rot_found;
  logic [ID_WIDTH-1:0]   rot_sel;
  logic [ID_WIDTH-1:0]   sel;
  logic                  pop;
  logic [7:0]            cnt_next;

  logic [DATA_WIDTH-1:0] in_word [NUM_PORTS];
  logic [ID_WIDTH-1:0]   rot_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0]  rot_req;

  // The output stage is blocked while it holds a word the downstream refuses.
  assign stall = out_valid_reg & ~out_full_n;

  // rot_req[k] is the request of port gnt+1+k. The last entry therefore maps
  // back to gnt itself, so the current owner is considered last on rotation.
  // NUM_PORTS is a power of two, so the index wraps by plain truncation.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign in_word[gi] = in_dout[gi*DATA_WIDTH +: DATA_WIDTH];
      assign rot_idx[gi] = gnt_reg + ID_WIDTH'(gi + 1);
      assign rot_req[gi] = in_empty_n[rot_idx[gi]];
      assign in_read[gi] = pop && (sel == ID_WIDTH'(gi));
    end
  endgenerate

  // Priority encoder over the rotated request vector. The lowest k wins. The
  // loop runs downward so that the last assignment is the lowest k.
  always_comb begin
    rot_found = 1'b0;
    rot_sel   = gnt_reg;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        rot_found = 1'b1;
        rot_sel   = rot_idx[k];
      end
    end
  end

  assign can_continue = in_empty_n[gnt_reg] && (cnt_reg < 8'(BURST_MAX));
  assign sel          = can_continue ? gnt_reg : rot_sel;
  assign pop          = en && !stall && (can_continue || rot_found);
  // A rotation restarts the burst count at 1, even when it lands on gnt itself.
  assign cnt_next     = can_continue ? (cnt_reg + 8'd1) : 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_din_reg   <= '0;
      out_src_reg   <= '0;
      gnt_reg       <= '0;
      cnt_reg       <= '0;
    end else if (!stall) begin
      if (pop) begin
        out_valid_reg <= 1'b1;
        out_din_reg   <= in_word[sel];
        out_src_reg   <= sel;
        gnt_reg       <= sel;
        cnt_reg       <= cnt_next;
      end else begin
        // Any held word was accepted this cycle, or no word was held.
        out_valid_reg <= 1'b0;
        // When enabled with no requester, the burst ends. The grant holds.
        if (en) begin
          cnt_reg <= 8'd0;
        end
      end
    end
  end

  assign out_write = out_valid_reg;
  assign out_din   = out_din_reg;
  assign out_src   = out_src_reg;

endmodule

// File: tb/tb_kernel_bc_fifo_rr_merge.sv
// ---------------------------------------------------------------------------
// Testbench for kernel_bc_fifo_rr_merge.
// Upstream FIFOs are modelled as circular buffers. Their state is updated at
// the negedge and driven 1 ns later. in_read is sampled 4 ns after the negedge.
// Expected words are pushed into a scoreboard queue when stimulus is issued.
// A monitor pops that queue and compares it with every accepted output word.
// ---------------------------------------------------------------------------
module tb_kernel_bc_fifo_rr_merge;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [NP-1:0]   in_empty_n;
  logic [NP*DW-1:0] in_dout;
  logic [NP-1:0]   in_read;
  logic            out_full_n;
  logic            out_write;
  logic [DW-1:0]   out_din;
  logic [IW-1:0]   out_src;

  int checks   = 0;
  int failures = 0;

  logic [IW+DW-1:0] exp_q[$];

  logic [DW-1:0] mem [NP][64];
  int            wp [NP];
  int            rp [NP];
  logic [NP-1:0] rd_cap;

  kernel_bc_fifo_rr_merge #(
    .NUM_PORTS (NP),
    .ID_WIDTH  (IW),
    .DATA_WIDTH(DW),
    .BURST_MAX (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_empty_n(in_empty_n),
    .in_dout   (in_dout),
    .in_read   (in_read),
    .out_full_n(out_full_n),
    .out_write (out_write),
    .out_din   (out_din),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mkw(input int t, input int p, input int i);
    return (64'(t) << 48) | (64'(p) << 32) | 64'(i);
  endfunction

  task automatic load(input int p, input logic [DW-1:0] d);
    mem[p][wp[p] % 64] = d;
    wp[p]++;
  endtask

  task automatic expect_word(input int p, input logic [DW-1:0] d);
    exp_q.push_back({IW'(p), d});
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Upstream FIFO model: apply the pop seen before the last posedge, then
  // drive the new heads, then sample in_read before the next posedge.
  initial begin
    for (int p = 0; p < NP; p++) begin
      wp[p] = 0;
      rp[p] = 0;
    end
    rd_cap     = '0;
    in_empty_n = '0;
    in_dout    = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++)
        if (rd_cap[p] && rp[p] != wp[p]) rp[p]++;
      #1;
      for (int p = 0; p < NP; p++) begin
        in_empty_n[p]        = (rp[p] != wp[p]);
        in_dout[p*DW +: DW]  = (rp[p] != wp[p]) ? mem[p][rp[p] % 64] : 64'h0;
      end
      #3;
      rd_cap = in_read;
      checks++;
      if ($countones(in_read) > 1) begin
        failures++;
        $display("FAIL in_read_onehot: got %b expected at most one bit", in_read);
      end
      if ((in_read & ~in_empty_n) != '0) begin
        failures++;
        $display("FAIL in_read_empty: got in_read %b with in_empty_n %b", in_read, in_empty_n);
      end
    end
  end

  // Monitor: each word the downstream accepts is compared with the scoreboard.
  initial begin
    logic [IW+DW-1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (out_write && out_full_n) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got src=%0d din=%h expected none", out_src, out_din);
        end else begin
          e = exp_q.pop_front();
          if (out_src !== e[DW+IW-1:DW] || out_din !== e[DW-1:0]) begin
            failures++;
            $display("FAIL out_word: got src=%0d din=%h expected src=%0d din=%h",
                     out_src, out_din, e[DW+IW-1:DW], e[DW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int src_tab [20];
    logic [NP-1:0] bit_exp;

    reset      = 1'b1;
    en         = 1'b0;
    out_full_n = 1'b1;

    // 1: reset state
    do_reset();
    #4;
    chk("reset_out_write", 64'(out_write), 64'd0);
    chk("reset_in_read",   64'(in_read),   64'd0);
    chk("reset_out_src",   64'(out_src),   64'd0);
    chk("reset_out_din",   out_din,        64'd0);
    @(negedge clk);
    en = 1'b1;

    // 2: single port 2, three words
    for (int i = 0; i < 3; i++) begin
      load(2, mkw(2, 2, i));
      expect_word(2, mkw(2, 2, i));
    end
    for (int c = 0; c < 3; c++) begin
      #4;
      chk("t2_in_read", 64'(in_read), 64'h4);
      @(negedge clk);
    end
    #4;
    chk("t2_in_read_idle", 64'(in_read), 64'h0);
    wait_drain();

    // 3: all ports busy, bursts of 4, back to port 0 after port 3
    do_reset();
    for (int i = 0; i < 8; i++) load(0, mkw(3, 0, i));
    for (int p = 1; p < NP; p++)
      for (int i = 0; i < 4; i++) load(p, mkw(3, p, i));
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < 4; i++) begin
        expect_word(p, mkw(3, p, i));
        src_tab[p*4 + i] = p;
      end
    for (int i = 4; i < 8; i++) begin
      expect_word(0, mkw(3, 0, i));
      src_tab[16 + i - 4] = 0;
    end
    for (int c = 0; c < 20; c++) begin
      #4;
      bit_exp = NP'(1) << src_tab[c];
      chk("t3_in_read", 64'(in_read), 64'(bit_exp));
      @(negedge clk);
    end
    wait_drain();

    // 4: port 1 with 10 words, no idle cycle across burst boundaries
    for (int i = 0; i < 10; i++) begin
      load(1, mkw(4, 1, i));
      expect_word(1, mkw(4, 1, i));
    end
    for (int c = 0; c < 10; c++) begin
      #4;
      chk("t4_in_read", 64'(in_read), 64'h2);
      @(negedge clk);
    end
    #4;
    chk("t4_in_read_idle", 64'(in_read), 64'h0);
    wait_drain();

    // 5: downstream full for 5 cycles while a word is held
    for (int i = 0; i < 6; i++) begin
      load(3, mkw(5, 3, i));
      expect_word(3, mkw(5, 3, i));
    end
    @(negedge clk);
    out_full_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #4;
      chk("t5_out_write", 64'(out_write), 64'd1);
      chk("t5_out_din",   out_din,        mkw(5, 3, 0));
      chk("t5_out_src",   64'(out_src),   64'd3);
      chk("t5_in_read",   64'(in_read),   64'h0);
      @(negedge clk);
    end
    out_full_n = 1'b1;
    #4;
    chk("t5_release_in_read", 64'(in_read), 64'h8);
    wait_drain();

    // 6: en=0 mid-burst, then reset while a word is held
    for (int i = 0; i < 6; i++) load(2, mkw(6, 2, i));
    expect_word(2, mkw(6, 2, 0));
    expect_word(2, mkw(6, 2, 1));
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    #4;
    chk("t6_en0_in_read",   64'(in_read),   64'h0);
    chk("t6_en0_out_write", 64'(out_write), 64'd1);
    @(negedge clk);
    #4;
    chk("t6_en0_drained",   64'(out_write), 64'd0);
    chk("t6_en0_no_read",   64'(in_read),   64'h0);
    @(negedge clk);
    en = 1'b1;                 // pops word 2 of port 2; it will be discarded
    @(negedge clk);
    reset      = 1'b1;
    out_full_n = 1'b0;
    en         = 1'b0;
    #4;
    chk("t6_held_before_reset", 64'(out_write), 64'd1);
    @(negedge clk);
    reset      = 1'b0;
    out_full_n = 1'b1;
    #4;
    chk("t6_reset_out_write", 64'(out_write), 64'd0);
    chk("t6_reset_in_read",   64'(in_read),   64'h0);
    @(negedge clk);
    // After the reset, gnt=0 and cnt=0, so rotation reaches port 1 before port 2.
    load(1, mkw(6, 1, 0));
    expect_word(1, mkw(6, 1, 0));
    for (int i = 3; i < 6; i++) expect_word(2, mkw(6, 2, i));
    en = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
